// File: rtl/exec_unit_mc.sv
// Execute stage: one ALU op per accepted instruction into a registered result/tag/flags output.
// Latency: 1 cycle for single-cycle ops, W_OPR+2 cycles for DIVU/REMU (iterative restoring divider).
// Backpressure: output register holds while v_o & stall_i; stall_o also held high while a divide is in flight.
module exec_unit_mc #(
  parameter int W_OPR   = 32,
  parameter int W_RD    = 4,
  parameter int W_FLAGS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               v_i,
  output logic               stall_o,
  input  logic [3:0]         op_i,
  input  logic               setf_i,
  input  logic               wben_i,
  input  logic [W_RD-1:0]    wb_r_i,
  input  logic [W_OPR-1:0]   opr0_i,
  input  logic [W_OPR-1:0]   opr1_i,
  input  logic               stall_i,
  output logic               v_o,
  output logic [W_OPR-1:0]   result_o,
  output logic [W_RD-1:0]    wb_r_o,
  output logic               wb_o,
  output logic [W_FLAGS-1:0] flags_o,
  output logic               busy_o
);

  localparam int LW = $clog2(W_OPR);
  localparam logic [LW-1:0] CNT_LAST = LW'(W_OPR - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       cnt_q, cnt_d;
  logic [W_OPR-1:0]    quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [W_RD-1:0]     dtag_q, dtag_d;
  logic                dwben_q, dwben_d, dsetf_q, dsetf_d, drem_q, drem_d;

  logic                v_q, v_d, wben_q, wben_d;
  logic [W_OPR-1:0]    res_q, res_d;
  logic [W_RD-1:0]     tag_q, tag_d;
  logic [W_FLAGS-1:0]  flags_q, flags_d;

  logic [W_OPR-1:0]    alu_res;
  logic [W_FLAGS-1:0]  alu_flags;
  logic                alu_wr, alu_upd, alu_c, alu_v;
  logic [W_OPR:0]      wide_t;
  logic signed [W_OPR:0] sar_t;

  logic [W_OPR:0]      rem_sh, rem_diff;
  logic [W_OPR-1:0]    div_res;
  logic [W_FLAGS-1:0]  div_flags;
  logic                load, div_in;

  assign load     = ~(v_q & stall_i);
  assign div_in   = v_i & ((op_i == 4'hC) | (op_i == 4'hD));
  assign v_o      = v_q;
  assign result_o = res_q;
  assign wb_r_o   = tag_q;
  assign wb_o     = v_q & wben_q;
  assign flags_o  = flags_q;
  assign busy_o   = (state_q != IDLE);

  // Single-cycle ALU; carry-in for ADC/SBB comes from flags as they stand at issue.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_wr  = wben_i;
    alu_upd = setf_i;
    wide_t  = '0;
    sar_t   = '0;
    case (op_i)
      4'h0, 4'h1: begin
        wide_t  = {1'b0, opr0_i} + {1'b0, opr1_i} + {{W_OPR{1'b0}}, (op_i == 4'h1) & flags_q[0]};
        alu_res = wide_t[W_OPR-1:0];
        alu_c   = wide_t[W_OPR];
        alu_v   = (opr0_i[W_OPR-1] == opr1_i[W_OPR-1]) && (alu_res[W_OPR-1] != opr0_i[W_OPR-1]);
      end
      4'h2, 4'h3, 4'hA: begin
        wide_t  = {1'b0, opr0_i} - {1'b0, opr1_i} - {{W_OPR{1'b0}}, (op_i == 4'h3) & flags_q[0]};
        alu_res = wide_t[W_OPR-1:0];
        alu_c   = wide_t[W_OPR];
        alu_v   = (opr0_i[W_OPR-1] != opr1_i[W_OPR-1]) && (alu_res[W_OPR-1] != opr0_i[W_OPR-1]);
        if (op_i == 4'hA) alu_wr = 1'b0;
      end
      4'h4: alu_res = opr0_i & opr1_i;
      4'h5: alu_res = opr0_i | opr1_i;
      4'h6: alu_res = opr0_i ^ opr1_i;
      // Shifts carry an extra bit so the last bit shifted out lands in C.
      4'h7: {alu_c, alu_res} = {1'b0, opr0_i} << opr1_i[LW-1:0];
      4'h8: {alu_res, alu_c} = {opr0_i, 1'b0} >> opr1_i[LW-1:0];
      4'h9: begin
        sar_t = $signed({opr0_i, 1'b0}) >>> opr1_i[LW-1:0];
        {alu_res, alu_c} = sar_t;
      end
      4'hB: alu_res = opr0_i * opr1_i;
      default: begin
        alu_wr  = 1'b0;
        alu_upd = 1'b0;
      end
    endcase
    alu_flags    = '0;
    alu_flags[0] = alu_c;
    alu_flags[1] = (alu_res == '0);
    alu_flags[2] = alu_res[W_OPR-1];
    alu_flags[3] = alu_v;
  end

  // Divider datapath: one restoring step; a zero divisor naturally yields all-ones quotient and rem = A.
  always_comb begin
    rem_sh       = {rem_q, quo_q[W_OPR-1]};
    rem_diff     = rem_sh - {1'b0, dvs_q};
    div_res      = drem_q ? rem_q : quo_q;
    div_flags    = '0;
    div_flags[1] = (div_res == '0);
    div_flags[2] = div_res[W_OPR-1];
    div_flags[3] = (dvs_q == '0);
  end

  // Next-state for divider FSM and output register, plus upstream stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    dtag_d  = dtag_q;
    dwben_d = dwben_q;
    dsetf_d = dsetf_q;
    drem_d  = drem_q;
    v_d     = v_q;
    res_d   = res_q;
    tag_d   = tag_q;
    wben_d  = wben_q;
    flags_d = flags_q;
    stall_o = v_q & stall_i;
    case (state_q)
      IDLE: begin
        if (div_in) begin
          stall_o = 1'b1;
          quo_d   = opr0_i;
          rem_d   = '0;
          dvs_d   = opr1_i;
          dtag_d  = wb_r_i;
          dwben_d = wben_i;
          dsetf_d = setf_i;
          drem_d  = (op_i == 4'hD);
          cnt_d   = '0;
          state_d = RUN;
          if (load) v_d = 1'b0;
        end else if (load) begin
          v_d = v_i;
          if (v_i) begin
            res_d  = alu_res;
            tag_d  = wb_r_i;
            wben_d = alu_wr;
            if (alu_upd) flags_d = alu_flags;
          end
        end
      end
      RUN: begin
        stall_o = 1'b1;
        if (!rem_diff[W_OPR]) begin
          rem_d = rem_diff[W_OPR-1:0];
          quo_d = {quo_q[W_OPR-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[W_OPR-1:0];
          quo_d = {quo_q[W_OPR-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
        if (load) v_d = 1'b0;
      end
      DONE: begin
        if (load) begin
          v_d     = 1'b1;
          res_d   = div_res;
          tag_d   = dtag_q;
          wben_d  = dwben_q;
          if (dsetf_q) flags_d = div_flags;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush kills the output and any divide but leaves architectural flags alone.
    if (flush_i) begin
      v_d     = 1'b0;
      wben_d  = 1'b0;
      flags_d = flags_q;
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      dtag_q  <= '0;
      dwben_q <= 1'b0;
      dsetf_q <= 1'b0;
      drem_q  <= 1'b0;
      v_q     <= 1'b0;
      res_q   <= '0;
      tag_q   <= '0;
      wben_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      dtag_q  <= dtag_d;
      dwben_q <= dwben_d;
      dsetf_q <= dsetf_d;
      drem_q  <= drem_d;
      v_q     <= v_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      wben_q  <= wben_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed bench for exec_unit_mc at W_OPR=32: ALU ops and flags, divider timing,
// downstream stall hold, flush and asynchronous reset mid-divide.
module tb_exec_unit_mc;

  logic        clk = 1'b0;
  logic        reset, flush_i, v_i, stall_o, setf_i, wben_i, stall_i;
  logic        v_o, wb_o, busy_o;
  logic [3:0]  op_i, wb_r_i, wb_r_o, flags_o;
  logic [31:0] opr0_i, opr1_i, result_o;

  int tests = 0;
  int fails = 0;

  exec_unit_mc #(.W_OPR(32), .W_RD(4), .W_FLAGS(4)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .v_i(v_i), .stall_o(stall_o),
    .op_i(op_i), .setf_i(setf_i), .wben_i(wben_i), .wb_r_i(wb_r_i),
    .opr0_i(opr0_i), .opr1_i(opr1_i), .stall_i(stall_i), .v_o(v_o),
    .result_o(result_o), .wb_r_o(wb_r_o), .wb_o(wb_o), .flags_o(flags_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic setf, input logic wben, input logic [3:0] tag);
    v_i = 1'b1; op_i = op; opr0_i = a; opr1_i = b; setf_i = setf; wben_i = wben; wb_r_i = tag;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush_i = 1'b0; v_i = 1'b0; stall_i = 1'b0; op_i = 4'h0;
    setf_i = 1'b0; wben_i = 1'b0; wb_r_i = 4'h0; opr0_i = '0; opr1_i = '0;
    #3;
    tests++; if (v_o !== 1'b0)       begin fails++; $display("FAIL reset_v_o got %0b want 0", v_o); end
    tests++; if (result_o !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 0", result_o); end
    tests++; if (flags_o !== 4'h0)   begin fails++; $display("FAIL reset_flags got %h want 0", flags_o); end
    tests++; if (busy_o !== 1'b0 || stall_o !== 1'b0 || wb_o !== 1'b0 || wb_r_o !== 4'h0)
      begin fails++; $display("FAIL reset_misc got busy=%0b stall=%0b wb=%0b tag=%0d want 0", busy_o, stall_o, wb_o, wb_r_o); end
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_add_adc();
    drive(4'h0, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b1, 4'h1);
    step();
    tests++; if (result_o !== 32'h8000_0000 || v_o !== 1'b1 || wb_o !== 1'b1)
      begin fails++; $display("FAIL add_ovf got res=%h v=%0b wb=%0b want 80000000 1 1", result_o, v_o, wb_o); end
    tests++; if (flags_o !== 4'hC) begin fails++; $display("FAIL add_ovf_flags got %h want c", flags_o); end
    drive(4'h1, 32'h0, 32'h0, 1'b1, 1'b1, 4'h2);
    step();
    tests++; if (result_o !== 32'h0 || flags_o !== 4'h2 || wb_r_o !== 4'h2)
      begin fails++; $display("FAIL adc_zero got res=%h flags=%h tag=%0d want 0 2 2", result_o, flags_o, wb_r_o); end
  endtask

  task automatic test_sub_sbb();
    drive(4'h2, 32'd5, 32'd7, 1'b1, 1'b1, 4'h3);
    step();
    tests++; if (result_o !== 32'hFFFF_FFFE || flags_o !== 4'h5)
      begin fails++; $display("FAIL sub_borrow got res=%h flags=%h want fffffffe 5", result_o, flags_o); end
    drive(4'h0, 32'd1, 32'd1, 1'b0, 1'b1, 4'h3);
    step();
    tests++; if (result_o !== 32'd2 || flags_o !== 4'h5)
      begin fails++; $display("FAIL add_nosetf got res=%h flags=%h want 2 5", result_o, flags_o); end
    drive(4'h3, 32'd10, 32'd0, 1'b1, 1'b1, 4'h3);
    step();
    tests++; if (result_o !== 32'd9 || flags_o !== 4'h0)
      begin fails++; $display("FAIL sbb_chain got res=%h flags=%h want 9 0", result_o, flags_o); end
  endtask

  task automatic test_logic_shift();
    drive(4'h7, 32'h8000_0001, 32'd1, 1'b1, 1'b1, 4'h4);
    step();
    tests++; if (result_o !== 32'h2 || flags_o !== 4'h1)
      begin fails++; $display("FAIL shl got res=%h flags=%h want 2 1", result_o, flags_o); end
    drive(4'h8, 32'h8000_0001, 32'd0, 1'b1, 1'b1, 4'h4);
    step();
    tests++; if (result_o !== 32'h8000_0001 || flags_o !== 4'h4)
      begin fails++; $display("FAIL shr0 got res=%h flags=%h want 80000001 4", result_o, flags_o); end
    drive(4'h9, 32'h8000_0008, 32'd4, 1'b1, 1'b1, 4'h4);
    step();
    tests++; if (result_o !== 32'hF800_0000 || flags_o !== 4'h5)
      begin fails++; $display("FAIL sar got res=%h flags=%h want f8000000 5", result_o, flags_o); end
    drive(4'h6, 32'h0000_F0F0, 32'h0000_F0F0, 1'b1, 1'b1, 4'h4);
    step();
    tests++; if (result_o !== 32'h0 || flags_o !== 4'h2)
      begin fails++; $display("FAIL xor got res=%h flags=%h want 0 2", result_o, flags_o); end
    drive(4'hB, 32'h0001_0000, 32'h0001_0001, 1'b1, 1'b1, 4'h4);
    step();
    tests++; if (result_o !== 32'h0001_0000 || flags_o !== 4'h0)
      begin fails++; $display("FAIL mull got res=%h flags=%h want 10000 0", result_o, flags_o); end
    v_i = 1'b0;
    step();
  endtask

  task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [3:0] exp_flags);
    int cyc = 0, n_st = 0, n_bz = 0;
    bit seen = 0;
    drive(op, a, b, 1'b1, 1'b1, 4'h3);
    #1;
    while (!seen && cyc < 100) begin
      if (stall_o) n_st++;
      if (busy_o) n_bz++;
      if (!stall_o) v_i = 1'b0;
      step();
      cyc++;
      if (v_o) seen = 1;
    end
    tests++; if (!seen || cyc != 34)
      begin fails++; $display("FAIL div_latency op=%h got %0d cycles (seen=%0b) want 34", op, cyc, seen); end
    tests++; if (n_st != 33 || n_bz != 33)
      begin fails++; $display("FAIL div_stall_busy op=%h got stall=%0d busy=%0d want 33 33", op, n_st, n_bz); end
    tests++; if (result_o !== exp_res || wb_r_o !== 4'h3 || wb_o !== 1'b1)
      begin fails++; $display("FAIL div_result op=%h got %h tag=%0d wb=%0b want %h 3 1", op, result_o, wb_r_o, wb_o, exp_res); end
    tests++; if (flags_o !== exp_flags)
      begin fails++; $display("FAIL div_flags op=%h got %h want %h", op, flags_o, exp_flags); end
    v_i = 1'b0;
    step();
    tests++; if (v_o !== 1'b0 || busy_o !== 1'b0)
      begin fails++; $display("FAIL div_nodup op=%h got v=%0b busy=%0b want 0 0", op, v_o, busy_o); end
  endtask

  task automatic test_divide();
    run_div(4'hC, 32'd100, 32'd7, 32'd14, 4'h0);
    run_div(4'hD, 32'd100, 32'd7, 32'd2, 4'h0);
    run_div(4'hC, 32'd5, 32'd0, 32'hFFFF_FFFF, 4'hC);
  endtask

  task automatic test_stall_hold();
    drive(4'h0, 32'd1, 32'd2, 1'b0, 1'b1, 4'h5);
    step();
    drive(4'h0, 32'd10, 32'd20, 1'b0, 1'b1, 4'h6);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL stall_prop cyc%0d got %0b want 1", i, stall_o); end
      step();
      tests++; if (v_o !== 1'b1 || result_o !== 32'd3 || wb_r_o !== 4'h5)
        begin fails++; $display("FAIL stall_hold cyc%0d got v=%0b res=%0d tag=%0d want 1 3 5", i, v_o, result_o, wb_r_o); end
    end
    stall_i = 1'b0;
    step();
    tests++; if (v_o !== 1'b1 || result_o !== 32'd30 || wb_r_o !== 4'h6)
      begin fails++; $display("FAIL stall_release got v=%0b res=%0d tag=%0d want 1 30 6", v_o, result_o, wb_r_o); end
    v_i = 1'b0;
    step();
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL stall_nodup got v=%0b want 0", v_o); end
  endtask

  task automatic test_div_stalled();
    drive(4'h0, 32'd1, 32'd1, 1'b0, 1'b1, 4'h1);
    step();
    drive(4'hC, 32'd100, 32'd7, 1'b0, 1'b1, 4'h3);
    stall_i = 1'b1;
    repeat (40) step();
    tests++; if (v_o !== 1'b1 || result_o !== 32'd2 || busy_o !== 1'b1 || stall_o !== 1'b1)
      begin fails++; $display("FAIL divstall_hold got v=%0b res=%0d busy=%0b stall=%0b want 1 2 1 1", v_o, result_o, busy_o, stall_o); end
    stall_i = 1'b0;
    #1;
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL divstall_release got stall=%0b want 0", stall_o); end
    v_i = 1'b0;
    step();
    tests++; if (v_o !== 1'b1 || result_o !== 32'd14 || wb_r_o !== 4'h3 || flags_o !== 4'hC)
      begin fails++; $display("FAIL divstall_result got v=%0b res=%0d tag=%0d flags=%h want 1 14 3 c", v_o, result_o, wb_r_o, flags_o); end
    step();
  endtask

  task automatic test_flush();
    drive(4'hC, 32'd1, 32'd1, 1'b1, 1'b1, 4'h2);
    step();
    repeat (9) step();
    flush_i = 1'b1;
    v_i = 1'b0;
    step();
    flush_i = 1'b0;
    tests++; if (v_o !== 1'b0 || busy_o !== 1'b0 || wb_o !== 1'b0 || flags_o !== 4'hC)
      begin fails++; $display("FAIL flush got v=%0b busy=%0b wb=%0b flags=%h want 0 0 0 c", v_o, busy_o, wb_o, flags_o); end
    drive(4'h0, 32'd2, 32'd3, 1'b0, 1'b1, 4'h7);
    step();
    tests++; if (v_o !== 1'b1 || result_o !== 32'd5 || wb_r_o !== 4'h7 || flags_o !== 4'hC)
      begin fails++; $display("FAIL post_flush_add got v=%0b res=%0d tag=%0d flags=%h want 1 5 7 c", v_o, result_o, wb_r_o, flags_o); end
  endtask

  task automatic test_reset_mid_div();
    drive(4'hC, 32'd100, 32'd7, 1'b1, 1'b1, 4'h3);
    repeat (5) step();
    reset = 1'b0;
    #1;
    tests++; if (v_o !== 1'b0 || result_o !== 32'h0 || flags_o !== 4'h0 || busy_o !== 1'b0 || wb_o !== 1'b0 || wb_r_o !== 4'h0)
      begin fails++; $display("FAIL async_reset got v=%0b res=%h flags=%h busy=%0b wb=%0b tag=%0d want all 0", v_o, result_o, flags_o, busy_o, wb_o, wb_r_o); end
    v_i = 1'b0;
    step();
    reset = 1'b1;
    #1;
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL reset_quiet_stall got %0b want 0", stall_o); end
    step();
    drive(4'hA, 32'd3, 32'd3, 1'b1, 1'b1, 4'h2);
    step();
    tests++; if (v_o !== 1'b1 || wb_o !== 1'b0 || flags_o !== 4'h2)
      begin fails++; $display("FAIL cmp_after_reset got v=%0b wb=%0b flags=%h want 1 0 2", v_o, wb_o, flags_o); end
    v_i = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_add_adc();
    test_sub_sbb();
    test_logic_shift();
    test_divide();
    test_stall_hold();
    test_div_stalled();
    test_flush();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
